sram_target: RTL and testbench
==============================

SRAM_TARGET -- requirements
Module: sram_target

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, which sets the word-address width (storage depth 2^ADDR_WIDTH x 32 bits).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, which sets the number of clock edges from a sampled read request to data drive; legal range 1..15.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port ram_ce_n, input, width 1: chip enable, active-low.
REQ-006 The block SHALL have port ram_we_n, input, width 1: write enable, active-low.
REQ-007 The block SHALL have port ram_oe_n, input, width 1: output enable, active-low.
REQ-008 The block SHALL have port ram_byte_en_n, input, width 4: byte lane enables, active-low; bit i selects data[8i+7:8i].
REQ-009 The block SHALL have port ram_addr, input, width 32: byte address; word index is ram_addr[ADDR_WIDTH+1:2].
REQ-010 The block SHALL have port ram_data, inout, width 32: shared data bus, high-impedance unless driving.
REQ-011 The block SHALL have port busy, output, width 1: high while a read is pending or being driven.
REQ-012 The block SHALL have port addr_err, output, width 1: one-cycle pulse on an access with nonzero ram_addr[31:ADDR_WIDTH+2] or ram_addr[1:0].
REQ-013 The block SHALL have port conflict_err, output, width 1: sticky flag, set when ce_n=0, we_n=0 and oe_n=0 are sampled together.

Function
REQ-014 A write SHALL be sampled at a clk edge where ce_n=0, we_n=0 and oe_n=1, and committed at that edge to enabled byte lanes only; write data comes from ram_data.
REQ-015 A held write over N cycles SHALL commit N times with the current values; the final value is the last sampled.
REQ-016 The FSM SHALL have states IDLE, RD_WAIT and RD_DRIVE; writes complete in IDLE without a state change.
REQ-017 In IDLE, a sampled read (ce_n=0, oe_n=0, we_n=1) SHALL latch the word index and load the latency counter with READ_LATENCY-1, then go to RD_WAIT, or to RD_DRIVE when READ_LATENCY=1.
REQ-018 In RD_WAIT, the counter SHALL decrement each cycle, with transition to RD_DRIVE when it reaches 0.
REQ-019 In RD_WAIT, a sampled address change SHALL restart the counter with the new index.
REQ-020 In RD_DRIVE, the block SHALL drive the stored word on ram_data, with bytes whose byte_en_n bit is 1 driven as 0x00.
REQ-021 In RD_DRIVE, drive SHALL be gated combinationally by ce_n=0 and oe_n=0, so ram_data is released in the same cycle either deasserts.
REQ-022 In RD_DRIVE, an address change SHALL return to RD_WAIT with a reloaded counter.
REQ-023 In RD_WAIT or RD_DRIVE, a sampled ce_n=1 or oe_n=1 SHALL return to IDLE.
REQ-024 busy SHALL be high in RD_WAIT and RD_DRIVE.
REQ-025 A read and a write in the same cycle after a read SHALL NOT both occur; a sampled write request in RD_WAIT or RD_DRIVE SHALL abort the read, go to IDLE and commit the write.
REQ-026 An out-of-range or misaligned access SHALL pulse addr_err.
REQ-027 An out-of-range or misaligned write SHALL be dropped.
REQ-028 An out-of-range or misaligned read SHALL drive 0x00000000 after the normal latency.
REQ-029 A conflict (REQ-013) SHALL be treated as no access: no commit, FSM to IDLE, bus released.

Reset
REQ-030 While rst=1, the block SHALL release ram_data combinationally.
REQ-031 At a clk edge with rst=1, the block SHALL set FSM to IDLE, counter 0, busy=0, addr_err=0 and conflict_err=0.
REQ-032 Storage contents SHALL NOT be affected by reset.
REQ-033 A reset during RD_WAIT or RD_DRIVE SHALL abandon the read with no drive afterward.

Configuration
REQ-034 With macro SRAM_TARGET_ACCESS_CNT_EN defined, the block SHALL add outputs rd_count[31:0] and wr_count[31:0], cleared by rst.
REQ-035 With SRAM_TARGET_ACCESS_CNT_EN defined, rd_count SHALL increment on each entry to RD_DRIVE and wr_count on each committed write edge, wrapping 0xFFFFFFFF->0.
REQ-036 Without SRAM_TARGET_ACCESS_CNT_EN, the ports and counters SHALL be absent.

Verification
REQ-037 Write 0x12345678 to addr 0x10 with byte_en_n=0000, then read addr 0x10 with READ_LATENCY=2 -> ram_data=0x12345678 from the 2nd edge after request; busy high throughout.
REQ-038 Write 0xAABBCCDD over 0x12345678 at 0x10 with byte_en_n=1010 -> read gives 0x12BB56DD; read with byte_en_n=1100 -> 0x000056DD.
REQ-039 Read 0x10, change addr to 0x14 during RD_WAIT -> counter restarts; 0x14 data appears READ_LATENCY edges after the change; 0x10 data never driven.
REQ-040 Assert ce_n=0, we_n=0, oe_n=0 -> conflict_err=1 and stays 1, no memory change, ram_data=Z; rst=1 one cycle -> conflict_err=0.
REQ-041 Access addr 0x00001000 with ADDR_WIDTH=10 -> addr_err pulses 1 cycle, write dropped, read returns 0x00000000.
REQ-042 Assert rst in RD_DRIVE -> ram_data=Z in the same cycle, IDLE after the edge, prior memory contents readable afterward.

Source files
------------

// File: rtl/sram_target.sv
// sram_target
//   Word-organised SRAM slave (2^ADDR_WIDTH x 32 bits) behind an asynchronous-
//   style SRAM pin interface. Writes commit on the sampling edge. Reads return
//   the addressed word READ_LATENCY edges after the request is first sampled.
//
// Parameters
//   ADDR_WIDTH   : word-address width, storage depth is 2^ADDR_WIDTH words
//   READ_LATENCY : edges from the sampled read request to data drive (1..15)
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   rst            : synchronous active-high reset (storage is not cleared)
//   ram_ce_n       : chip enable, active-low
//   ram_we_n       : write enable, active-low
//   ram_oe_n       : output enable, active-low
//   ram_byte_en_n  : byte lane enables, active-low, bit i <-> data[8i+7:8i]
//   ram_addr       : byte address, word index is ram_addr[ADDR_WIDTH+1:2]
//   ram_data       : shared bidirectional data bus, released unless driving
//   busy           : high while a read is pending or being driven
//   addr_err       : one-cycle pulse for a new out-of-range/misaligned access
//   conflict_err   : sticky, set when ce_n, we_n and oe_n are all sampled low
//
// Optional build macro
//   SRAM_TARGET_ACCESS_CNT_EN : adds rd_count / wr_count access counters
//     rd_count : reads that reached the data-drive phase (wraps)
//     wr_count : committed write edges (wraps)

module sram_target #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce_n,
  input  logic        ram_we_n,
  input  logic        ram_oe_n,
  input  logic [3:0]  ram_byte_en_n,
  input  logic [31:0] ram_addr,
  inout  wire  [31:0] ram_data,
  output logic        busy,
  output logic        addr_err,
  output logic        conflict_err
`ifdef SRAM_TARGET_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] RELOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DRIVE = 2'd2
  } state_e;

  // True when the byte address lies outside the array or is not word aligned.
  function automatic logic addr_bad(input logic [31:0] a);
    return ((a >> (ADDR_WIDTH + 2)) != 32'd0) || (a[1:0] != 2'd0);
  endfunction

  // Word index carried in a byte address.
  function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_WIDTH+1:2];
  endfunction

  // Storage array, deliberately outside the reset domain.
  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic        busy_q, busy_d;
  logic        addr_err_q, addr_err_d;
  logic        conflict_err_q, conflict_err_d;

  logic        wr_req_s;
  logic        rd_req_s;
  logic        conf_s;
  logic        bad_s;
  logic        addr_chg_s;
  logic        wr_commit_s;
  logic        restart_s;
  logic        drive_en_s;
  logic [31:0] lane_mask_s;

  // Decode the sampled pin state into request types.
  always_comb begin
    wr_req_s   = ~ram_ce_n & ~ram_we_n &  ram_oe_n;
    rd_req_s   = ~ram_ce_n &  ram_we_n & ~ram_oe_n;
    conf_s     = ~ram_ce_n & ~ram_we_n & ~ram_oe_n;
    bad_s      = addr_bad(ram_addr);
    addr_chg_s = (ram_addr != addr_q);
  end

  // Next-state logic for the read FSM, write commit and error flags.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    addr_err_d     = 1'b0;
    conflict_err_d = conflict_err_q | conf_s;
    wr_commit_s    = 1'b0;
    restart_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_req_s) begin
          wr_commit_s = ~bad_s;
          addr_err_d  = bad_s;
        end else if (rd_req_s) begin
          restart_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RD_WAIT, RD_DRIVE: begin
        if (conf_s) begin
          // Conflict counts as no access: just drop the read.
          state_d = IDLE;
        end else if (wr_req_s) begin
          // A write aborts the read and still commits on this edge.
          state_d     = IDLE;
          wr_commit_s = ~bad_s;
          addr_err_d  = bad_s;
        end else if (!rd_req_s) begin
          state_d = IDLE;
        end else if (addr_chg_s) begin
          restart_s = 1'b1;
        end else if (state_q == RD_WAIT) begin
          // The counter was loaded with READ_LATENCY-1; the edge taking
          // it to zero is the edge that starts driving.
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = RD_DRIVE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d = RD_DRIVE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh read (from IDLE or after an address change) reloads the latency.
    if (restart_s) begin
      addr_d     = ram_addr;
      cnt_d      = RELOAD;
      addr_err_d = bad_s;
      state_d    = (READ_LATENCY == 1) ? RD_DRIVE : RD_WAIT;
    end else begin
      addr_d = addr_d;
    end

    busy_d = (state_d != IDLE);

    // Word presented during the drive phase; bad addresses read as zero.
    if (addr_bad(addr_d)) begin
      rd_word_d = 32'd0;
    end else begin
      rd_word_d = mem_q[word_idx(addr_d)];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      addr_q         <= 32'd0;
      rd_word_q      <= 32'd0;
      busy_q         <= 1'b0;
      addr_err_q     <= 1'b0;
      conflict_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      rd_word_q      <= rd_word_d;
      busy_q         <= busy_d;
      addr_err_q     <= addr_err_d;
      conflict_err_q <= conflict_err_d;
    end
  end

  // Byte-lane write into storage; reset blocks the commit but never clears data.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (!ram_byte_en_n[i]) begin
          mem_q[word_idx(ram_addr)][8*i +: 8] <= ram_data[8*i +: 8];
        end
      end
    end
  end

  // Drive is gated by the live pins so the bus is released in the same cycle
  // that ce_n/oe_n rise, we_n falls or rst is asserted.
  always_comb begin
    drive_en_s  = (state_q == RD_DRIVE) & ~rst & ~ram_ce_n & ~ram_oe_n & ram_we_n;
    lane_mask_s = {{8{~ram_byte_en_n[3]}}, {8{~ram_byte_en_n[2]}},
                   {8{~ram_byte_en_n[1]}}, {8{~ram_byte_en_n[0]}}};
  end

  assign ram_data     = drive_en_s ? (rd_word_q & lane_mask_s) : 32'hzzzz_zzzz;
  assign busy         = busy_q;
  assign addr_err     = addr_err_q;
  assign conflict_err = conflict_err_q;

`ifdef SRAM_TARGET_ACCESS_CNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic        rd_entry_s;

  // Count drive-phase entries and committed write edges, wrapping naturally.
  always_comb begin
    rd_entry_s = (state_d == RD_DRIVE) && ((state_q != RD_DRIVE) || restart_s);
    if (rd_entry_s) begin
      rd_count_d = rd_count_q + 32'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
    if (wr_commit_s) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Access counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_target.sv
// Testbench for sram_target: randomized bus traffic checked every cycle
// against a transaction-level model (memory array plus "read pending for N
// edges" bookkeeping), plus directed sequences with literal expectations.
// A pullup on the data bus makes a released bus read as all ones.

module tb_sram_target;

  localparam int AW = 10;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce_n;
  logic        ram_we_n;
  logic        ram_oe_n;
  logic [3:0]  ram_byte_en_n;
  logic [31:0] ram_addr;
  logic [31:0] tb_wdata;
  wire  [31:0] ram_data;
  wire         busy;
  wire         addr_err;
  wire         conflict_err;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  pullup (ram_data);
  assign ram_data = ram_we_n ? 32'hzzzz_zzzz : tb_wdata;

  sram_target #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk          (clk),
    .rst          (rst),
    .ram_ce_n     (ram_ce_n),
    .ram_we_n     (ram_we_n),
    .ram_oe_n     (ram_oe_n),
    .ram_byte_en_n(ram_byte_en_n),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .busy         (busy),
    .addr_err     (addr_err),
    .conflict_err (conflict_err)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [1 << AW];
  bit          m_pend;
  bit          m_err;
  bit          m_conf;
  logic [31:0] m_paddr;
  int          m_age;

  function automatic bit is_bad(input logic [31:0] a);
    return ((a >> (AW + 2)) != 32'd0) || (a[1:0] != 2'd0);
  endfunction

  // Bus value the model requires right now (all ones = released).
  function automatic logic [31:0] exp_bus();
    logic [31:0] w;
    w = 32'hFFFF_FFFF;
    if (!rst && m_pend && (m_age >= RL) && !ram_ce_n && !ram_oe_n && ram_we_n) begin
      w = is_bad(m_paddr) ? 32'd0 : m_mem[m_paddr[AW+1:2]];
      for (int i = 0; i < 4; i++) begin
        if (ram_byte_en_n[i]) w[8*i +: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_age  <= 0;
      m_err  <= 1'b0;
      m_conf <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!ram_ce_n && !ram_we_n && !ram_oe_n) begin
        m_conf <= 1'b1;
        m_pend <= 1'b0;
      end else if (!ram_ce_n && !ram_we_n) begin
        m_pend <= 1'b0;
        if (is_bad(ram_addr)) begin
          m_err <= 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!ram_byte_en_n[i]) m_mem[ram_addr[AW+1:2]][8*i +: 8] <= tb_wdata[8*i +: 8];
          end
        end
      end else if (!ram_ce_n && !ram_oe_n) begin
        if (!m_pend || (ram_addr != m_paddr)) begin
          m_pend  <= 1'b1;
          m_paddr <= ram_addr;
          m_age   <= 1;
          m_err   <= is_bad(ram_addr);
        end else if (m_age < 1000) begin
          m_age <= m_age + 1;
        end
      end else begin
        m_pend <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, after inputs settle.
  always @(negedge clk) begin
    #1;
    if (checking) begin
      check("busy", {31'd0, busy}, {31'd0, m_pend});
      check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
      check("conflict_err", {31'd0, conflict_err}, {31'd0, m_conf});
      if (ram_we_n) check("ram_data", ram_data, exp_bus());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit ce, input bit we, input bit oe,
                       input logic [3:0] ben, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; ram_ce_n = ce; ram_we_n = we; ram_oe_n = oe;
    ram_byte_en_n = ben; ram_addr = a; tb_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ben);
    drive(1'b0, 1'b0, 1'b0, 1'b1, ben, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] ben);
    drive(1'b0, 1'b0, 1'b1, 1'b0, ben, a, 32'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] idx;
    int r;
    idx = 32'($urandom_range(0, 15)) << 2;
    r = $urandom_range(0, 9);
    if (r <= 6) return idx;
    else if (r == 7) return 32'h0000_1000 + idx;
    else if (r == 8) return idx + 32'($urandom_range(1, 3));
    else return 32'h8000_0010;
  endfunction

  initial begin
    rst = 1'b1; ram_ce_n = 1'b1; ram_we_n = 1'b1; ram_oe_n = 1'b1;
    ram_byte_en_n = 4'h0; ram_addr = 32'd0; tb_wdata = 32'd0;

    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'd0, 32'd0);
    checking = 1'b1;
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_conflict", {31'd0, conflict_err}, 32'd0);
    check("reset_bus", ram_data, 32'hFFFF_FFFF);

    // Fill the whole array so every later read has a known value.
    for (int i = 0; i < (1 << AW); i++) wr(32'(i) << 2, $urandom, 4'h0);

    // Basic write then read with latency 2.
    wr(32'h0, 32'h0102_0304, 4'h0);
    wr(32'h10, 32'h1234_5678, 4'h0);
    rd(32'h10, 4'h0); #2;
    check("rd_edge0_busy", {31'd0, busy}, 32'd0);
    rd(32'h10, 4'h0); #2;
    check("rd_edge1_busy", {31'd0, busy}, 32'd1);
    check("rd_edge1_bus", ram_data, 32'hFFFF_FFFF);
    rd(32'h10, 4'h0); #2;
    check("rd_edge2_bus", ram_data, 32'h1234_5678);
    check("rd_edge2_busy", {31'd0, busy}, 32'd1);

    // Partial byte-lane write, then masked read lanes.
    wr(32'h10, 32'hAABB_CCDD, 4'b1010);
    rd(32'h10, 4'h0); rd(32'h10, 4'h0); rd(32'h10, 4'h0); #2;
    check("lane_write", ram_data, 32'h12BB_56DD);
    rd(32'h10, 4'b1100); #2;
    check("lane_read_mask", ram_data, 32'h0000_56DD);
    idle(); #2;
    check("oe_release_same_cycle", ram_data, 32'hFFFF_FFFF);

    // Address change during the wait phase restarts the latency.
    wr(32'h14, 32'hCAFE_F00D, 4'h0);
    rd(32'h10, 4'h0);
    rd(32'h14, 4'h0); #2;
    check("chg_wait_bus", ram_data, 32'hFFFF_FFFF);
    rd(32'h14, 4'h0); #2;
    check("chg_edge1_bus", ram_data, 32'hFFFF_FFFF);
    rd(32'h14, 4'h0); #2;
    check("chg_edge2_bus", ram_data, 32'hCAFE_F00D);

    // Conflict: sticky flag, no commit, bus released.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0BAD_BEEF);
    idle(); #2;
    check("conflict_set", {31'd0, conflict_err}, 32'd1);
    check("conflict_bus", ram_data, 32'hFFFF_FFFF);
    idle(); #2;
    check("conflict_sticky", {31'd0, conflict_err}, 32'd1);
    rd(32'h10, 4'h0); rd(32'h10, 4'h0); rd(32'h10, 4'h0); #2;
    check("conflict_no_commit", ram_data, 32'h12BB_56DD);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'd0, 32'd0);
    idle(); #2;
    check("conflict_cleared", {31'd0, conflict_err}, 32'd0);

    // Out-of-range write and read.
    wr(32'h0000_1000, 32'h5555_5555, 4'h0);
    idle(); #2;
    check("oor_wr_err", {31'd0, addr_err}, 32'd1);
    idle(); #2;
    check("oor_err_pulse", {31'd0, addr_err}, 32'd0);
    rd(32'h0000_1000, 4'h0);
    rd(32'h0000_1000, 4'h0); #2;
    check("oor_rd_err", {31'd0, addr_err}, 32'd1);
    rd(32'h0000_1000, 4'h0); #2;
    check("oor_rd_zero", ram_data, 32'h0);
    rd(32'h0, 4'h0); rd(32'h0, 4'h0); rd(32'h0, 4'h0); #2;
    check("oor_wr_dropped", ram_data, 32'h0102_0304);

    // Reset while driving.
    rd(32'h14, 4'h0); rd(32'h14, 4'h0); rd(32'h14, 4'h0); #2;
    check("pre_rst_bus", ram_data, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h14, 32'd0); #2;
    check("rst_release", ram_data, 32'hFFFF_FFFF);
    rd(32'h14, 4'h0); #2;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_bus", ram_data, 32'hFFFF_FFFF);
    rd(32'h14, 4'h0); rd(32'h14, 4'h0); #2;
    check("post_rst_data", ram_data, 32'hCAFE_F00D);

    // Randomized bursts checked by the per-cycle compare.
    repeat (400) begin
      int op;
      int len;
      logic [31:0] a;
      logic [3:0]  ben;
      op  = $urandom_range(0, 9);
      len = $urandom_range(1, 6);
      a   = pick_addr();
      for (int k = 0; k < len; k++) begin
        ben = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        if (op <= 3)      rd(a, ben);
        else if (op <= 5) wr(a, $urandom, ben);
        else if (op == 6) drive(1'b0, 1'b0, 1'b0, 1'b0, ben, a, $urandom);
        else if (op == 7) drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), ben, a, $urandom);
        else if (op == 8) begin
          if (k == len - 1) idle();
          else rd(a, ben);
        end else begin
          drive(1'b1, 1'($urandom), 1'b1, 1'($urandom), ben, a, 32'd0);
        end
      end
    end

    idle();
    idle();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
